// File: rtl/dmem_responder.sv
// dmem_responder
//
// Memory-side responder for the datapath load/store port. It accepts one
// load or store at a time over a valid/ready request channel. It stalls for
// WAIT_CYCLES cycles, then performs the access against a word-addressed
// array. The result is returned over a valid/ready response channel.
//
// Parameters
//   DEPTH        memory size in 32-bit words (power of two, >= 4)
//   WAIT_CYCLES  stall cycles between request acceptance and access (0..15)
//
// Ports
//   Clk        system clock, rising edge
//   Reset      asynchronous active-low reset
//   ReqValid   request present
//   ReqReady   responder can accept a request (IDLE only)
//   ReqWrite   1 = store, 0 = load
//   Address    byte address
//   WriteData  store data
//   RespValid  response present (RESP only)
//   RespReady  datapath accepts the response
//   ReadData   load result; 0 for stores and faulting requests
//   RespErr    request faulted, qualified by RespValid
//   Busy       transaction in flight
//
// Build option
//   DMEM_ALIGN_CHECK_EN  when defined, a non-word-aligned address faults.
//                        When undefined, Address[1:0] is ignored.
//
// The memory array has no reset, so its contents survive Reset.

module dmem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic        RespValid,
  input  logic        RespReady,
  output logic [31:0] ReadData,
  output logic        RespErr,
  output logic        Busy
);

  localparam int          AW         = $clog2(DEPTH);
  // One past the last valid byte address. The compare is 33 bits wide so
  // that DEPTH*4 is representable.
  localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH) << 2;
  localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt;

  // Request latched on the accepting edge. This is data only, so it has no reset.
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          acc_en;
  logic          acc_write;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [AW-1:0] acc_idx;
  logic          acc_fault;
  logic          mem_we;

  // Returns 1 for addresses that must not touch the array. Comparing the
  // whole byte address against DEPTH*4 is the same as Address[31:2] >= DEPTH.
  function automatic logic addr_fault(input logic [31:0] a);
    logic f;
    f = ({1'b0, a} >= BYTE_LIMIT);
`ifdef DMEM_ALIGN_CHECK_EN
    f = f | (a[1:0] != 2'b00);
`endif
    return f;
  endfunction

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state and access selection. With WAIT_CYCLES == 0 the access
  // happens on the accepting edge, so it uses the live request inputs.
  // Otherwise it uses the latched copy when the wait counter reaches 1.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    acc_en    = 1'b0;
    acc_write = write_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    case (state)
      ST_IDLE: begin
        if (ReqValid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            acc_en    = 1'b1;
            acc_write = ReqWrite;
            acc_addr  = Address;
            acc_wdata = WriteData;
            state_nxt = ST_RESP;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt == 4'd1) begin
          acc_en    = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (RespReady) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign acc_idx   = acc_addr[AW+1:2];
  assign acc_fault = addr_fault(acc_addr);
  // The state register holds IDLE while Reset is low, but a zero-wait
  // build would still see ReqValid. Gating on Reset keeps a store from
  // committing while reset is asserted.
  assign mem_we    = acc_en & acc_write & ~acc_fault & Reset;

  // Wait counter
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wait_cnt <= 4'd0;
    end else if (accept) begin
      wait_cnt <= WAIT_INIT;
    end else if (state == ST_WAIT) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Request capture
  always_ff @(posedge Clk) begin
    if (accept) begin
      write_q <= ReqWrite;
      addr_q  <= Address;
      wdata_q <= WriteData;
    end
  end

  // Memory array
  always_ff @(posedge Clk) begin
    if (mem_we) mem[acc_idx] <= acc_wdata;
  end

  // Response registers. They change only on the access edge, so they stay
  // stable for as long as RESP is stalled by RespReady.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (acc_en) begin
      err_q   <= acc_fault;
      rdata_q <= (!acc_write && !acc_fault) ? mem[acc_idx] : 32'd0;
    end
  end

  assign ReqReady  = (state == ST_IDLE);
  assign RespValid = (state == ST_RESP);
  assign Busy      = (state != ST_IDLE);
  assign ReadData  = rdata_q;
  assign RespErr   = err_q;

endmodule
